// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - op and state encodings shared by the multiply/divide unit
package mul_div_unit_pkg;

    // The control decoder drives these same op codes.
    localparam logic [1:0] MDU_MUL   = 2'b00;
    localparam logic [1:0] MDU_MULHU = 2'b01;
    localparam logic [1:0] MDU_DIVU  = 2'b10;
    localparam logic [1:0] MDU_REMU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Multiply ops leave the answer in the low half of the accumulator for MUL and
    // in the high half for MULHU. Divide ops leave the quotient low and the remainder high.
    function automatic logic select_high(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one combinational shift-add or restoring-division iteration
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        fits      = rem_shift >= {1'b0, operand};
        // A successful trial leaves a value below the divisor, so WIDTH bits suffice.
        diff      = rem_shift[WIDTH-1:0] - operand;
        acc_next  = acc;
        if (is_div) begin
            if (fits) begin
                acc_next = {diff, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else if (acc[0]) begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative unsigned MUL/MULHU/DIVU/REMU unit, one bit per cycle
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   operand;
    logic [1:0]         op_q;
    logic               div_by_zero;
    logic               last;

    assign div_by_zero = op[1] && (b == '0);
    assign last        = (cnt == CW'(WIDTH - 1));
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (operand),
        .is_div   (op_q[1]),
        .acc_next (acc_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = div_by_zero ? S_DONE : S_RUN;
            S_RUN:  if (last)  state_next = S_DONE;
            default:           state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            operand <= '0;
            op_q    <= '0;
            result  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        cnt     <= '0;
                        // Divide keeps the divisor and shifts the dividend; multiply the reverse.
                        operand <= op[1] ? b : a;
                        acc     <= {{WIDTH{1'b0}}, (op[1] ? a : b)};
                        if (div_by_zero) begin
                            result <= op[0] ? a : '1;
                        end
                    end
                end
                S_RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        result <= select_high(op_q) ? acc_step[2*WIDTH-1:WIDTH]
                                                    : acc_step[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed bench with a cycle-level reference model for mul_div_unit
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int vectors = 0;
    int miscompares = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        p = 64'(x) * 64'(y);
        case (o)
            MDU_MUL:   return p[31:0];
            MDU_MULHU: return p[63:32];
            MDU_DIVU:  return (y == 0) ? 32'hFFFF_FFFF : x / y;
            default:   return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Model: cycles of busy still to come; done is the last of them.
    int          left = 0;
    logic [31:0] pending = '0;
    logic [31:0] m_result = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            left     <= 0;
            m_result <= '0;
        end else if (left == 0) begin
            if (start) begin
                if (op[1] && b == 0) begin
                    left     <= 1;
                    m_result <= ref_result(op, a, b);
                end else begin
                    left    <= 33;
                    pending <= ref_result(op, a, b);
                end
            end
        end else begin
            left <= left - 1;
            if (left == 2) m_result <= pending;
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check32("busy", {31'b0, busy}, {31'b0, left != 0});
        check32("done", {31'b0, done}, {31'b0, left == 1});
        check32("result", result, m_result);
    end

    // Issue one op, scramble inputs after the latch edge, and measure cycles to done.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
        int lat;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_int({name, "_latency"}, lat, exp_lat);
        check32({name, "_value"}, result, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        logic seen_done;
        logic [31:0] x;
        logic [31:0] y;

        repeat (2) @(posedge clk);
        #1;
        check32("reset_busy", {31'b0, busy}, 32'd0);
        check32("reset_result", result, 32'd0);
        rst = 1'b0;

        run_op("mul_7x6", MDU_MUL, 32'd7, 32'd6, 32'd42, 33);
        run_op("mulhu_max", MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mul_max", MDU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
        run_op("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7", MDU_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op("divu_5_9", MDU_DIVU, 32'd5, 32'd9, 32'd0, 33);
        run_op("divu_by0", MDU_DIVU, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_by0", MDU_REMU, 32'd1234, 32'd0, 32'd1234, 1);
        run_op("divu_max_1", MDU_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
        run_op("remu_big", MDU_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 33);
        run_op("mulhu_split", MDU_MULHU, 32'h8000_0000, 32'd6, 32'd3, 33);

        for (int i = 0; i < 6; i++) begin
            x = $urandom;
            y = (i == 5) ? 32'd3 : $urandom;
            run_op("mix", 2'(i), x, y, ref_result(2'(i), x, y), 33);
        end

        // Restart requests while running and in the DONE cycle are ignored.
        @(posedge clk); #1;
        start = 1'b1; op = MDU_MUL; a = 32'd7; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = MDU_DIVU; a = 32'd100; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 6;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_int("restart_latency", lat, 33);
        check32("restart_value", result, 32'd42);
        start = 1'b1; op = MDU_MUL; a = 32'd2; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        check32("done_cycle_start_busy", {31'b0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check32("held_result", result, 32'd42);
        check32("held_busy", {31'b0, busy}, 32'd0);

        // Reset in the middle of a divide.
        @(posedge clk); #1;
        start = 1'b1; op = MDU_DIVU; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check32("abort_busy", {31'b0, busy}, 32'd0);
        check32("abort_result", result, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check32("abort_no_done", {31'b0, seen_done}, 32'd0);
        run_op("mul_3x3", MDU_MUL, 32'd3, 32'd3, 32'd9, 33);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
